// File: rtl/vedic_mult_pipe.sv
// rtl/vedic_mult_pipe.sv - pipelined recursive Vedic (Urdhva-Tiryagbhyam) multiplier with valid/ready flow control
// Sign-magnitude wrapper around an unsigned recursive core; one register stage per level above 2x2.

module vedic_leaf2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_a;
  logic cross_b;
  logic high;
  logic carry;

  assign cross_a = a[1] & b[0];
  assign cross_b = a[0] & b[1];
  assign high    = a[1] & b[1];
  assign carry   = cross_a & cross_b;

  assign p[0] = a[0] & b[0];
  assign p[1] = cross_a ^ cross_b;
  assign p[2] = high ^ carry;
  assign p[3] = high & carry;
endmodule

module vedic_node #(
  parameter int S = 4
) (
  input  logic           clk,
  input  logic           en,
  input  logic [S-1:0]   a,
  input  logic [S-1:0]   b,
  output logic [2*S-1:0] p
);
  localparam int H = S / 2;

  logic [S-1:0]   p_ll;
  logic [S-1:0]   p_hl;
  logic [S-1:0]   p_lh;
  logic [S-1:0]   p_hh;
  logic [2*S-1:0] sum;

  if (H == 2) begin : g_leaf
    vedic_leaf2 u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(p_ll));
    vedic_leaf2 u_hl (.a(a[S-1:H]), .b(b[H-1:0]), .p(p_hl));
    vedic_leaf2 u_lh (.a(a[H-1:0]), .b(b[S-1:H]), .p(p_lh));
    vedic_leaf2 u_hh (.a(a[S-1:H]), .b(b[S-1:H]), .p(p_hh));
  end else begin : g_sub
    vedic_node #(.S(H)) u_ll (.clk(clk), .en(en), .a(a[H-1:0]), .b(b[H-1:0]), .p(p_ll));
    vedic_node #(.S(H)) u_hl (.clk(clk), .en(en), .a(a[S-1:H]), .b(b[H-1:0]), .p(p_hl));
    vedic_node #(.S(H)) u_lh (.clk(clk), .en(en), .a(a[H-1:0]), .b(b[S-1:H]), .p(p_lh));
    vedic_node #(.S(H)) u_hh (.clk(clk), .en(en), .a(a[S-1:H]), .b(b[S-1:H]), .p(p_hh));
  end

  // vertical terms concatenate, the two crosswise terms land at the half-width offset
  assign sum = {p_hh, p_ll}
             + {{H{1'b0}}, p_hl, {H{1'b0}}}
             + {{H{1'b0}}, p_lh, {H{1'b0}}};

  always_ff @(posedge clk) begin
    if (en) begin
      p <= sum;
    end
  end
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int LAT = $clog2(WIDTH) - 1;
  localparam int H   = WIDTH / 2;

  if (WIDTH != 4 && WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be 4, 8, 16 or 32");
  end

  logic               advance;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               in_neg;
  logic [WIDTH-1:0]   p_ll;
  logic [WIDTH-1:0]   p_hl;
  logic [WIDTH-1:0]   p_lh;
  logic [WIDTH-1:0]   p_hh;
  logic               last_vld;
  logic               last_neg;
  logic [TAG_W-1:0]   last_tag;
  logic [2*WIDTH-1:0] mag_p;
  logic [2*WIDTH-1:0] fin_p;
  logic               vld_q;
  logic [2*WIDTH-1:0] p_q;
  logic [TAG_W-1:0]   tag_q;

  assign advance  = !vld_q || out_ready;
  assign in_ready = advance;

  // -2^(WIDTH-1) negates to itself, which read as unsigned is exactly its magnitude
  assign mag_a  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign mag_b  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  assign in_neg = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  if (H == 2) begin : g_leaf
    vedic_leaf2 u_ll (.a(mag_a[H-1:0]),     .b(mag_b[H-1:0]),     .p(p_ll));
    vedic_leaf2 u_hl (.a(mag_a[WIDTH-1:H]), .b(mag_b[H-1:0]),     .p(p_hl));
    vedic_leaf2 u_lh (.a(mag_a[H-1:0]),     .b(mag_b[WIDTH-1:H]), .p(p_lh));
    vedic_leaf2 u_hh (.a(mag_a[WIDTH-1:H]), .b(mag_b[WIDTH-1:H]), .p(p_hh));
  end else begin : g_sub
    vedic_node #(.S(H)) u_ll (.clk(clk), .en(advance), .a(mag_a[H-1:0]),     .b(mag_b[H-1:0]),     .p(p_ll));
    vedic_node #(.S(H)) u_hl (.clk(clk), .en(advance), .a(mag_a[WIDTH-1:H]), .b(mag_b[H-1:0]),     .p(p_hl));
    vedic_node #(.S(H)) u_lh (.clk(clk), .en(advance), .a(mag_a[H-1:0]),     .b(mag_b[WIDTH-1:H]), .p(p_lh));
    vedic_node #(.S(H)) u_hh (.clk(clk), .en(advance), .a(mag_a[WIDTH-1:H]), .b(mag_b[WIDTH-1:H]), .p(p_hh));
  end

  // valid, sign and tag ride alongside the sub-product registers of the lower levels
  if (LAT == 1) begin : g_meta_none
    assign last_vld = in_valid;
    assign last_neg = in_neg;
    assign last_tag = in_tag;
  end else begin : g_meta
    logic             vld_s [LAT-1];
    logic             neg_s [LAT-1];
    logic [TAG_W-1:0] tag_s [LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < LAT - 1; k++) begin
          vld_s[k] <= 1'b0;
        end
      end else if (advance) begin
        vld_s[0] <= in_valid;
        for (int k = 1; k < LAT - 1; k++) begin
          vld_s[k] <= vld_s[k-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        neg_s[0] <= in_neg;
        tag_s[0] <= in_tag;
        for (int k = 1; k < LAT - 1; k++) begin
          neg_s[k] <= neg_s[k-1];
          tag_s[k] <= tag_s[k-1];
        end
      end
    end

    assign last_vld = vld_s[LAT-2];
    assign last_neg = neg_s[LAT-2];
    assign last_tag = tag_s[LAT-2];
  end

  assign mag_p = {p_hh, p_ll}
               + {{H{1'b0}}, p_hl, {H{1'b0}}}
               + {{H{1'b0}}, p_lh, {H{1'b0}}};
  assign fin_p = last_neg ? -mag_p : mag_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else if (advance) begin
      vld_q <= last_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      p_q   <= fin_p;
      tag_q <= last_tag;
    end
  end

  assign out_valid = vld_q;
  assign out_p     = (vld_q && !rst) ? p_q : '0;
  assign out_tag   = (vld_q && !rst) ? tag_q : '0;
endmodule

// File: doc/vedic_mult_pipe.md
VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; legal values 4, 8, 16, 32; any other value is an elaboration error.
REQ-002 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-003 SHALL have localparam LAT = log2(WIDTH)-1: pipeline latency in cycles (16 gives 3; 4 gives 1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 in_a  input  WIDTH  multiplicand.
REQ-009 in_b  input  WIDTH  multiplier.
REQ-010 in_signed  input  1  per-operation mode: 1 means two's-complement operands, 0 means unsigned.
REQ-011 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_p  output  2*WIDTH  product.
REQ-015 out_tag  output  TAG_W  tag of the operation on out_p.

Function
REQ-016 Core SHALL be a recursive Vedic (Urdhva-Tiryagbhyam) unsigned multiplier: 2x2 leaf cells from AND gates and half adders; each level combines four half-width partial products with shifted adds.
REQ-017 A register stage SHALL sit after each recursion level above 2x2. Valid, tag and sign travel in lockstep with the data, so LAT stages in total.
REQ-018 Transfer rules:
- an input transfer occurs when in_valid && in_ready;
- an output transfer occurs when out_valid && out_ready.
REQ-019 Stall control:
- advance = !out_valid || out_ready;
- in_ready = advance, combinational;
- when advance=0, every stage holds its contents.
REQ-020 Operations SHALL emerge in acceptance order. With no stalls, a result is valid exactly LAT cycles after its accepting edge.
REQ-021 Stages holding bubbles (valid=0) SHALL still advance whenever advance=1. Bubbles are not collapsed.
REQ-022 Signed operations:
- each operand is converted to its magnitude at the input;
- the product magnitude is negated when the operand signs differ;
- negation uses the sign bit carried through the pipeline, applied in the last stage.
REQ-023 Magnitude of -2^(WIDTH-1) SHALL be represented as unsigned 2^(WIDTH-1) with no overflow. out_p SHALL always be the exact 2*WIDTH-bit product.
REQ-024 Unsigned operations SHALL produce a*b mod 2^(2*WIDTH), which is exact.
REQ-025 When out_valid=1 and out_ready=0, out_p, out_tag and out_valid SHALL stay stable until the transfer.
REQ-026 Simultaneous output transfer and input transfer in the same cycle SHALL be supported at full throughput: one operation per cycle.
REQ-027 in_a, in_b, in_signed and in_tag SHALL be ignored when in_valid=0.

Reset
REQ-028 While rst=1, at the clock edge all stage valid bits SHALL clear, so out_valid=0 on the following cycle.
REQ-029 While rst=1, out_p and out_tag SHALL read zero, and in_ready SHALL read 1 once the valids are clear.
REQ-030 Reset mid-operation SHALL discard every in-flight operation. No discarded result may appear after reset is released.
REQ-031 Data registers need not be reset, but out_p SHALL be gated to zero while out_valid=0.

Verification (WIDTH=16, TAG_W=4, LAT=3)
REQ-032 Unsigned 0xFFFF*0xFFFF, tag 5, out_ready=1 -> 3 cycles later out_valid=1, out_p=0xFFFE0001, out_tag=5.
REQ-033 Signed 0x8000*0x8000 -> 0x40000000; signed 0xFFFF*0x0003 -> 0xFFFFFFFD; same operands unsigned -> 0x0002FFFD.
REQ-034 Back-to-back 10 random ops, out_ready=1 -> 10 consecutive out_valid cycles, results in order and matching the reference model.
REQ-035 Backpressure scenario:
- stimulus: 4 ops issued, out_ready=0 from the cycle the first result appears;
- required: in_ready=0 and the output is held stable;
- then out_ready=1 -> remaining results drain in order with none lost or duplicated.
REQ-036 Reset mid-operation: rst=1 for 1 cycle with 3 ops in flight -> out_valid=0 for the next 3 cycles; a new op is accepted immediately after reset and its correct result appears after 3 cycles.
REQ-037 Parameter sweep WIDTH=4, 8 and 32 (LAT 1, 2, 4): exhaustive check at WIDTH=4 in both modes, and random checks at 8 and 32 including ±max and -2^(WIDTH-1) corners.
